// File: rtl/alu_uart_tx_interface_pkg.sv
// Shared types and constants for the ALU-to-UART return-path bridge.
package alu_uart_tx_interface_pkg;

    localparam int DEFAULT_NB_DATA = 8;

    localparam int STAT_ZERO  = 0;
    localparam int STAT_CARRY = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEND      = 2'b01,
        WAIT_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_uart_tx_interface_if.sv
// ALU result / UART TX handshake bundle; slave is the bridge, master drives it.
interface alu_uart_tx_interface_if
    import alu_uart_tx_interface_pkg::*;
#(
    parameter int NB_DATA = DEFAULT_NB_DATA
) ();

    logic               i_result_valid;
    logic [NB_DATA-1:0] i_result;
    logic               i_zero;
    logic               i_carry;
    logic               i_tx_busy;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_overrun;
    logic               o_error;

    modport slave (
        input  i_result_valid, i_result, i_zero, i_carry, i_tx_busy, i_tx_done,
        output o_tx_start, o_tx_data, o_busy, o_overrun, o_error
    );

    modport master (
        output i_result_valid, i_result, i_zero, i_carry, i_tx_busy, i_tx_done,
        input  o_tx_start, o_tx_data, o_busy, o_overrun, o_error
    );

endinterface

// File: rtl/alu_uart_tx_interface_tx_watchdog.sv
// Per-byte watchdog: up-counter with clear/enable, expired at TIMEOUT_CYCLES-1.
module alu_uart_tx_interface_tx_watchdog #(
    parameter int NB_TIMEOUT     = 17,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [NB_TIMEOUT-1:0] COUNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + NB_TIMEOUT'(1);
        end
    end

    assign o_expired = (count == COUNT_LAST);

endmodule

// File: rtl/alu_uart_tx_interface.sv
// Captures one ALU result plus flags and ships it to the UART TX as a
// {result, status} byte frame, one start pulse per byte.
module alu_uart_tx_interface
    import alu_uart_tx_interface_pkg::*;
#(
    parameter int NB_DATA        = DEFAULT_NB_DATA,
    parameter bit SEND_STATUS    = 1'b1,
    parameter int NB_TIMEOUT     = 17,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic                    i_clk,
    input logic                    i_reset,
    alu_uart_tx_interface_if.slave bus
);

    // state     | meaning
    // IDLE      | waiting for i_result_valid, buffers hold last frame
    // SEND      | byte ready, waiting for TX to go idle
    // WAIT_DONE | byte started, waiting for i_tx_done or watchdog expiry

    localparam logic LAST_IDX = SEND_STATUS;

    state_t             state;
    logic               byte_idx;
    logic [NB_DATA-1:0] result_buf;
    logic [NB_DATA-1:0] status_buf;
    logic [NB_DATA-1:0] status_byte;
    logic [NB_DATA-1:0] tx_byte;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               overrun;
    logic               error;
    logic               wd_clear;
    logic               wd_enable;
    logic               wd_expired;

    always_comb begin
        status_byte             = '0;
        status_byte[STAT_ZERO]  = bus.i_zero;
        status_byte[STAT_CARRY] = bus.i_carry;
    end

    assign tx_byte   = byte_idx ? status_buf : result_buf;
    assign wd_clear  = (state == SEND) && !bus.i_tx_busy;
    assign wd_enable = (state == WAIT_DONE);

    alu_uart_tx_interface_tx_watchdog #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tx_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (wd_clear),
        .i_enable  (wd_enable),
        .o_expired (wd_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            byte_idx   <= 1'b0;
            result_buf <= '0;
            status_buf <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            overrun    <= 1'b0;
            error      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            error    <= 1'b0;
            overrun  <= bus.i_result_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.i_result_valid) begin
                        result_buf <= bus.i_result;
                        status_buf <= status_byte;
                        byte_idx   <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.i_tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= tx_byte;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // a done seen alongside our own start belongs to the previous byte
                    if (bus.i_tx_done && !tx_start) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            byte_idx <= 1'b1;
                            state    <= SEND;
                        end
                    end else if (wd_expired) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_tx_start = tx_start;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_overrun  = overrun;
    assign bus.o_error    = error;

endmodule
